// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Shared UART constants and the receiver state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam int CLKS_PER_BIT_DEFAULT = 820;
   localparam int DATA_BITS            = 8;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_IDLE = 3'd4
   } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module : uart_rx_sync
// Two-flop synchronizer for an asynchronous, idle-high input.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   // Reset to 1 so an idle line does not look like a start edge after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module : uart_rx
// 8N1 UART receiver, LSB first, mid-bit sampling with start-bit validation.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Rx_Serial,
   output logic [7:0] Rx_Parallel,
   output logic       Rx_Valid,
   output logic       Framing_Error
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] c_cnt_last = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] c_cnt_half = CW'(HALF - 1);
   localparam logic [2:0]    c_idx_last = 3'(DATA_BITS - 1);

   logic                 w_rx_s;

   rx_state_t            r_state,  w_state_nxt;
   logic [CW-1:0]        r_cnt,    w_cnt_nxt;
   logic [2:0]           r_bit_idx, w_bit_idx_nxt;
   logic [DATA_BITS-1:0] r_shift,  w_shift_nxt;
   logic [DATA_BITS-1:0] r_data,   w_data_nxt;
   logic                 r_valid,  w_valid_nxt;
   logic                 r_ferr,   w_ferr_nxt;

   uart_rx_sync u_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (Rx_Serial),
      .o_sync  (w_rx_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= RX_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_data    <= w_data_nxt;
         r_valid   <= w_valid_nxt;
         r_ferr    <= w_ferr_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt + 1'b1;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_data_nxt    = r_data;
      w_valid_nxt   = 1'b0;
      w_ferr_nxt    = 1'b0;

      unique case (r_state)
         RX_IDLE: begin
            w_cnt_nxt = '0;
            if (!w_rx_s) w_state_nxt = RX_START;
         end

         RX_START: begin
            // Line must still be low at mid-start-bit, otherwise it was a glitch.
            if (r_cnt == c_cnt_half) begin
               w_cnt_nxt = '0;
               if (!w_rx_s) begin
                  w_state_nxt   = RX_DATA;
                  w_bit_idx_nxt = '0;
               end else begin
                  w_state_nxt = RX_IDLE;
               end
            end
         end

         RX_DATA: begin
            if (r_cnt == c_cnt_last) begin
               w_cnt_nxt              = '0;
               w_shift_nxt[r_bit_idx] = w_rx_s;
               if (r_bit_idx == c_idx_last) w_state_nxt   = RX_STOP;
               else                         w_bit_idx_nxt = r_bit_idx + 3'd1;
            end
         end

         RX_STOP: begin
            if (r_cnt == c_cnt_last) begin
               w_cnt_nxt = '0;
               if (w_rx_s) begin
                  w_data_nxt  = r_shift;
                  w_valid_nxt = 1'b1;
                  w_state_nxt = RX_IDLE;
               end else begin
                  w_ferr_nxt  = 1'b1;
                  w_state_nxt = RX_WAIT_IDLE;
               end
            end
         end

         RX_WAIT_IDLE: begin
            // A held-low line (break) must not be mistaken for new start bits.
            w_cnt_nxt = '0;
            if (w_rx_s) w_state_nxt = RX_IDLE;
         end

         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = RX_IDLE;
         end
      endcase
   end

   assign Rx_Parallel   = r_data;
   assign Rx_Valid      = r_valid;
   assign Framing_Error = r_ferr;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module : tb_uart_rx
// Self-checking bench for uart_rx with a timed expected-strobe scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;

   typedef struct {
      logic       ferr;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       Rx_Serial;
   logic [7:0] Rx_Parallel;
   logic       Rx_Valid;
   logic       Framing_Error;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   logic [7:0] last_good = 8'h00;
   exp_t       sb[$];

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk           (clk),
      .reset         (reset),
      .Rx_Serial     (Rx_Serial),
      .Rx_Parallel   (Rx_Parallel),
      .Rx_Valid      (Rx_Valid),
      .Framing_Error (Framing_Error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Called on a negedge with the receiver idle; returns on the negedge ending the stop bit.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      exp_t e;
      e.ferr = ~stop;
      e.data = stop ? d : last_good;
      e.cyc  = cyc + 3 + HALF + 9 * CPB;
      sb.push_back(e);
      if (stop) last_good = d;
      Rx_Serial = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         Rx_Serial = d[i];
         repeat (CPB) @(negedge clk);
      end
      Rx_Serial = stop;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40 * CPB) begin
         @(negedge clk);
         n++;
      end
      check_eq("sb_drain", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset && (Rx_Valid || Framing_Error)) begin
         check_eq("strobe_excl", {31'd0, Rx_Valid & Framing_Error}, 0);
         if (sb.size() == 0) begin
            check_eq("unexpected_strobe", {30'd0, Rx_Valid, Framing_Error}, 0);
         end else begin
            e = sb.pop_front();
            check_eq("strobe_kind", {30'd0, Rx_Valid, Framing_Error}, e.ferr ? 32'd1 : 32'd2);
            check_eq("rx_data", {24'd0, Rx_Parallel}, {24'd0, e.data});
            check_eq("strobe_cyc", cyc, e.cyc);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b1;
      Rx_Serial = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_data",  {24'd0, Rx_Parallel}, 0);
      check_eq("rst_valid", {31'd0, Rx_Valid}, 0);
      check_eq("rst_ferr",  {31'd0, Framing_Error}, 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      send_frame(8'hA5, 1'b1);
      repeat (2 * CPB) @(negedge clk);
      drain();

      // Short low pulse: gone before the start check.
      Rx_Serial = 1'b0;
      repeat (5) @(negedge clk);
      Rx_Serial = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      send_frame(8'h3C, 1'b1);
      repeat (2 * CPB) @(negedge clk);
      drain();

      // Bad stop bit, then a long break.
      send_frame(8'h55, 1'b0);
      repeat (40 * CPB) @(negedge clk);
      check_eq("break_hold", {24'd0, Rx_Parallel}, {24'd0, last_good});
      Rx_Serial = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      drain();

      // Reset pulse in the middle of data bit 4 of 0xFF.
      Rx_Serial = 1'b0;
      repeat (CPB) @(negedge clk);
      Rx_Serial = 1'b1;
      repeat (4 * CPB + HALF) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("midrst_data",  {24'd0, Rx_Parallel}, 0);
      check_eq("midrst_valid", {31'd0, Rx_Valid}, 0);
      check_eq("midrst_ferr",  {31'd0, Framing_Error}, 0);
      reset     = 1'b0;
      last_good = 8'h00;
      repeat (6 * CPB) @(negedge clk);
      check_eq("midrst_after", {24'd0, Rx_Parallel}, 0);
      send_frame(8'h81, 1'b1);
      repeat (2 * CPB) @(negedge clk);
      drain();

      // Zero idle gap between frames.
      send_frame(8'h12, 1'b1);
      send_frame(8'h34, 1'b1);
      repeat (2 * CPB) @(negedge clk);
      drain();

      for (int b = 0; b < 128; b++) send_frame(8'(b), 1'b1);
      repeat (2 * CPB) @(negedge clk);
      drain();
      check_eq("final_data", {24'd0, Rx_Parallel}, 32'h7F);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, 8N1, LSB first; the receive-side counterpart of `UART_Tx`, using the same bit period. It takes the asynchronous `Rx_Serial` line, detects and validates the start bit, and samples each data bit at mid-bit. It presents each received byte on `Rx_Parallel` with a one-cycle `Rx_Valid` strobe, or raises `Framing_Error` when the stop bit is bad. It sits between the board RX pin and any byte consumer, and it is loop-back testable against `UART_Tx`.

## Interface
- `CLKS_PER_BIT`, default 820: clock cycles per UART bit; must be ≥ 4. `HALF = CLKS_PER_BIT/2` (integer division).
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  reset, synchronous and active-high.
- `Rx_Serial`  in  1  asynchronous serial line; idles high.
- `Rx_Parallel`  out  8  last good received byte; held until the next good byte.
- `Rx_Valid`  out  1  one-cycle strobe: `Rx_Parallel` just updated.
- `Framing_Error`  out  1  one-cycle strobe: stop bit sampled low; byte discarded.

## Operation
- **Synchronizer.** `Rx_Serial` passes through 2 flops to give `rx_s`. Both flops reset to 1.
- **Counters.**
  - `cnt`: width `$clog2(CLKS_PER_BIT)`; cleared on every state change and every bit sample.
  - `bit_idx`: 3 bits.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE.
- **IDLE:** on `rx_s==0`, go to START with `cnt=0`.
- **START:** `cnt` increments.
  - At `cnt==HALF-1`: if `rx_s==0`, go to DATA with `cnt=0`, `bit_idx=0`.
  - Otherwise it is a glitch: return to IDLE with no output.
- **DATA:** at `cnt==CLKS_PER_BIT-1`:
  - `shift[bit_idx] <= rx_s`, `cnt=0`.
  - If `bit_idx==7`, go to STOP; else increment `bit_idx`.
- **STOP:** at `cnt==CLKS_PER_BIT-1`:
  - If `rx_s==1`: `Rx_Parallel<=shift`, `Rx_Valid<=1`, go to IDLE.
  - Else: `Framing_Error<=1`, `Rx_Parallel` unchanged, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s==1`, then go to IDLE. This prevents a break (line held low) from retriggering frames.
- **Strobes:** `Rx_Valid` and `Framing_Error` are registered, default 0 every cycle, and are never high together.

## Timing
- **Reset values** (the cycle after `reset` is sampled high):
  - `Rx_Parallel=8'h00`, `Rx_Valid=0`, `Framing_Error=0`.
  - State IDLE; `cnt`, `bit_idx` and `shift` all 0; sync flops 1.
- **Reset mid-frame:** abandons the frame with no strobe. Reception restarts on the first falling edge after reset deasserts.
- **Edge detection:** let edge E be the clock edge where sync flop 1 first captures 0. The FSM leaves IDLE at edge E+2.
- **Sampling points:**
  - Start check at E+2+HALF.
  - Data bit n sampled at E+2+HALF+(n+1)·CLKS_PER_BIT.
  - Stop decision at E+2+HALF+9·CLKS_PER_BIT; the strobe is high for exactly the following cycle.
- **Glitch rejection:** a low pulse shorter than about HALF cycles that has ended by the start check produces no output.
- **Back-to-back frames:** the stop decision lands at mid-stop-bit, so the FSM is in IDLE about HALF cycles before the next start edge. Consecutive frames with a 1-bit stop are received with no loss.
- **No handshake:** there is no backpressure. The consumer must capture on `Rx_Valid`. `Rx_Parallel` stays stable for at least 10·CLKS_PER_BIT cycles after a strobe.

## Structure
- **Shared package `uart_pkg`** (also used by `UART_Tx`):
  - `CLKS_PER_BIT` default (820).
  - `DATA_BITS = 8`.
  - Rx state enum typedef.
- **Sub-module `uart_rx_sync`:** 2-flop synchronizer, reset to 1. It is reusable for other asynchronous inputs.
- Everything else is the FSM and datapath in one always block plus registered outputs.

## Test plan
- **Single byte:** `CLKS_PER_BIT=16`; drive 0xA5 as 8N1 → `Rx_Parallel=8'hA5`. `Rx_Valid` is high exactly 1 cycle, at E+2+8+144 = E+154; `Framing_Error` stays 0.
- **Loop-back sweep:** `UART_Tx` drives `uart_rx` with `CLKS_PER_BIT=820`, bytes 0x00–0x7F → 128 `Rx_Valid` strobes, each `Rx_Parallel` equal to the byte sent, in order.
- **Glitch rejection:** 5-cycle low pulse on an idle line (`CLKS_PER_BIT=16`) → no strobe; then a 0x3C frame is received correctly.
- **Framing error / break:** frame 0x55 with stop bit low, then the line held low for 40 bit times → one `Framing_Error` pulse. `Rx_Parallel` keeps its prior value, and there are no further strobes until the line returns high.
- **Reset mid-frame:** `reset` for 1 cycle during data bit 4 of 0xFF → no strobe; outputs read 0. The next frame, 0x81, is received correctly.
- **Back-to-back frames:** 0x12 then 0x34 with zero idle gap → two `Rx_Valid` pulses, 10·CLKS_PER_BIT cycles apart, with the correct data.
